// File: rtl/penc_pkg.sv
// Shared constants and helpers for the registered priority encoder family.
package penc_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Decrement with wrap from 0 to n-1, so a pointer never leaves 0..n-1.
    function automatic int wrap_dec(input int idx, input int n);
        return (idx == 0) ? n - 1 : idx - 1;
    endfunction

endpackage

// File: rtl/penc_hi.sv
// Combinational highest-set-bit encoder: index of the top set bit plus an any-set flag.
module penc_hi #(
    parameter  int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         any
);

    always_comb begin
        // NOTE: defaults before the loop keep every path assigned, so no latch is inferred.
        idx = '0;
        any = 1'b0;
        // Ascending scan: the last hit, i.e. the highest set bit, wins.
        for (int i = 0; i < N; i++) begin
            if (vec[i]) begin
                idx = W'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/penc_rr_reg.sv
// Registered N-input priority encoder, fixed or round-robin, with a valid/ready output.
module penc_rr_reg
    import penc_pkg::*;
#(
    parameter  int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         mode,
    output logic [W-1:0] out_idx,
    output logic         out_valid,
    input  logic         out_ready
);

    logic [W-1:0] ptr;
    logic [N-1:0] mask;
    logic [N-1:0] masked;
    logic [W-1:0] m_idx;
    logic [W-1:0] r_idx;
    logic [W-1:0] winner;
    logic         m_any;
    logic         r_any;
    logic         load;
    logic         accept;

    // Sources at or below ptr get first look; the rest are reached by wrapping.
    always_comb begin
        mask = '0;
        for (int i = 0; i < N; i++) begin
            mask[i] = (i <= int'(ptr));
        end
    end

    assign masked = req & mask;

    penc_hi #(.N(N)) u_hi_masked (
        .vec (masked),
        .idx (m_idx),
        .any (m_any)
    );

    penc_hi #(.N(N)) u_hi_req (
        .vec (req),
        .idx (r_idx),
        .any (r_any)
    );

    assign winner = (mode == MODE_RR && m_any) ? m_idx : r_idx;
    assign load   = !out_valid || out_ready;
    assign accept = out_valid && out_ready;

    // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_idx   <= '0;
            ptr       <= W'(N - 1);
        end else begin
            // Just-served source drops to lowest priority; ptr is frozen in fixed mode.
            if (accept && mode == MODE_RR) begin
                ptr <= W'(wrap_dec(int'(out_idx), N));
            end
            if (load) begin
                if (r_any) begin
                    out_idx   <= winner;
                    out_valid <= 1'b1;
                end else begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_penc_rr_reg.sv
// Scoreboard bench for penc_rr_reg: an N=8 and an N=5 instance, directed vectors.
module tb_penc_rr_reg;
    import penc_pkg::*;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic       mode;
    logic [2:0] idx;
    logic       valid;
    logic       rdy;

    logic       rst5;
    logic [4:0] req5;
    logic       mode5;
    logic [2:0] idx5;
    logic       valid5;
    logic       rdy5;

    int n_checks = 0;
    int n_pass   = 0;

    int q8[$];
    int q5[$];

    penc_rr_reg #(.N(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .mode      (mode),
        .out_idx   (idx),
        .out_valid (valid),
        .out_ready (rdy)
    );

    penc_rr_reg #(.N(5)) dut5 (
        .clk       (clk),
        .rst       (rst5),
        .req       (req5),
        .mode      (mode5),
        .out_idx   (idx5),
        .out_valid (valid5),
        .out_ready (rdy5)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitors: every accepted grant is compared with the oldest expected index.
    always @(negedge clk) begin
        if (valid && rdy) begin
            if (q8.size() == 0) begin
                check("grant8_unexpected", int'(idx), -1);
            end else begin
                check("grant8", int'(idx), q8.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (valid5 && rdy5) begin
            if (q5.size() == 0) begin
                check("grant5_unexpected", int'(idx5), -1);
            end else begin
                check("grant5", int'(idx5), q5.pop_front());
            end
        end
    end

    initial begin
        logic [7:0] fx_vec [4];
        int         fx_exp [4];
        logic [7:0] stall_req [4];
        int         rr_exp [6];
        int         rr5_exp [4];

        fx_vec    = '{8'b0010_0110, 8'b1111_1111, 8'b0000_0001, 8'b0001_1000};
        fx_exp    = '{5, 7, 0, 4};
        stall_req = '{8'b1100_0000, 8'b0000_0001, 8'b1111_1111, 8'b1100_0000};
        rr_exp    = '{7, 2, 0, 7, 2, 0};
        rr5_exp   = '{4, 0, 4, 0};

        rst   = 1'b1;
        req   = '0;
        mode  = MODE_FIXED;
        rdy   = 1'b1;
        rst5  = 1'b1;
        req5  = '0;
        mode5 = MODE_FIXED;
        rdy5  = 1'b1;
        step();
        step();

        check("rst_valid", int'(valid), 0);
        check("rst_idx", int'(idx), 0);
        check("rst_ptr", int'(dut.ptr), 7);
        rst = 1'b0;

        // Fixed priority, back-to-back grants at full throughput.
        for (int k = 0; k < 4; k++) begin
            req = fx_vec[k];
            q8.push_back(fx_exp[k]);
            step();
        end
        req = '0;
        step();
        check("fixed_idle_valid", int'(valid), 0);
        check("fixed_idle_idx_hold", int'(idx), 4);
        check("fixed_ptr_frozen", int'(dut.ptr), 7);

        // Round-robin rotation; an idle cycle between grants lets ptr settle.
        mode = MODE_RR;
        for (int k = 0; k < 6; k++) begin
            req = 8'b1000_0101;
            q8.push_back(rr_exp[k]);
            step();
            req = '0;
            step();
        end
        check("rr_ptr_after_0", int'(dut.ptr), 7);

        // Wrap: 0 served, then 0 alone is granted again, then 7 beats 0.
        req = 8'b0000_0001;
        q8.push_back(0);
        step();
        req = '0;
        step();
        check("wrap_ptr", int'(dut.ptr), 7);
        req = 8'b1000_0001;
        q8.push_back(7);
        step();
        req = '0;
        step();
        check("wrap_ptr_after_7", int'(dut.ptr), 6);

        // Stall: grant 3 must hold while req churns.
        req = 8'b0000_1000;
        q8.push_back(3);
        step();
        rdy = 1'b0;
        for (int k = 0; k < 4; k++) begin
            req = stall_req[k];
            step();
            check("stall_idx", int'(idx), 3);
            check("stall_valid", int'(valid), 1);
        end
        rdy = 1'b1;
        req = '0;
        step();
        check("stall_ptr_after_3", int'(dut.ptr), 2);
        req = 8'b1100_0000;
        q8.push_back(7);
        step();
        req = '0;
        step();

        // Reset while a grant is pending and unaccepted.
        rdy = 1'b0;
        req = 8'b0010_0000;
        step();
        check("pending_valid", int'(valid), 1);
        rst = 1'b1;
        req = '0;
        step();
        check("midrst_valid", int'(valid), 0);
        check("midrst_idx", int'(idx), 0);
        check("midrst_ptr", int'(dut.ptr), 7);
        rst = 1'b0;
        rdy = 1'b1;
        req = 8'b0101_0000;
        q8.push_back(6);
        step();
        req = '0;
        step();

        // Non-power-of-two instance.
        check("rst5_valid", int'(valid5), 0);
        check("rst5_idx", int'(idx5), 0);
        check("rst5_ptr", int'(dut5.ptr), 4);
        rst5  = 1'b0;
        mode5 = MODE_RR;
        for (int k = 0; k < 4; k++) begin
            req5 = 5'b10001;
            q5.push_back(rr5_exp[k]);
            step();
            check("ptr5_range", int'(dut5.ptr < 3'd5), 1);
            req5 = '0;
            step();
            check("ptr5_range", int'(dut5.ptr < 3'd5), 1);
        end
        mode5 = MODE_FIXED;
        req5  = 5'b01110;
        q5.push_back(3);
        step();
        req5 = '0;
        step();
        step();

        check("q8_drained", q8.size(), 0);
        check("q5_drained", q5.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
